// File: rtl/acc_level_pkg.sv
// Shared types, defaults and level search for the acceleration level quantizer.
// Hysteresis on level changes is enabled by defining ACC_LEVEL_HYST_EN.
package acc_level_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_NUM_LEVELS = 8;
  localparam int DEF_AVG_LOG2   = 2;
  localparam int DEF_HOLD_CNT   = 3;
  localparam int DEF_HYST       = 16;

  // Comparison width: wide enough that bound +/- margin never wraps.
  localparam int MAX_W = 32;
  localparam int MAX_L = 64;

  typedef enum logic [1:0] {
    FILL,
    STABLE,
    PENDING
  } state_t;

  typedef logic signed [MAX_W:0] cmp_t;

  // First k (from 0) with avg > bnd[k]; nl-1 when nothing matches.
  function automatic int pick_level(
    input cmp_t avg,
    input cmp_t bnd [MAX_L-1],
    input int   nl
  );
    int lvl;
    lvl = nl - 1;
    for (int k = MAX_L - 2; k >= 0; k--)
      if (k < nl - 1 && avg > bnd[k])
        lvl = k;
    return lvl;
  endfunction

endpackage

// File: rtl/acc_moving_avg.sv
// Power-of-two sliding window with running sum and registered average.
// Empty slots count as zero until the window has filled once.
module acc_moving_avg
  import acc_level_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample,
  input  logic                     sample_valid,
  input  logic                     clear,
  output logic signed [DATA_W-1:0] avg,
  output logic                     upd,
  output logic                     full
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = DATA_W + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;

  logic signed [DATA_W-1:0] win [DEPTH];
  logic signed [SW-1:0]     sum;
  logic signed [SW-1:0]     sum_next;
  logic [FW-1:0]            fill;

  assign sum_next = sum + SW'(sample)
                  - SW'(win[DEPTH-1]);
  assign full = (fill == FW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        win[i] <= '0;
      sum  <= '0;
      fill <= '0;
      avg  <= '0;
      upd  <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++)
        win[i] <= '0;
      sum  <= '0;
      fill <= '0;
      avg  <= '0;
      upd  <= 1'b0;
    end else begin
      upd <= sample_valid;
      if (sample_valid) begin
        win[0] <= sample;
        for (int i = 1; i < DEPTH; i++)
          win[i] <= win[i-1];
        sum <= sum_next;
        avg <= DATA_W'(sum_next >>> AVG_LOG2);
        if (!full)
          fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_level_quantizer.sv
// Averages acceleration samples and commits a debounced level index.
// Define ACC_LEVEL_HYST_EN to add a hysteresis margin around bounds.
module acc_level_quantizer
  import acc_level_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int HOLD_CNT   = DEF_HOLD_CNT,
  parameter int HYST       = DEF_HYST
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic signed [DATA_W-1:0] i_sample,
  input  logic                     i_sample_valid,
  input  logic                     i_clear,
  input  logic [(NUM_LEVELS-1)*DATA_W-1:0] i_bounds,
  output logic signed [DATA_W-1:0] o_avg,
  output logic [$clog2(NUM_LEVELS)-1:0] o_level,
  output logic                     o_level_valid,
  output logic                     o_level_changed
);

  localparam int LW = $clog2(NUM_LEVELS);
  localparam int CW = $clog2(HOLD_CNT + 1);

  state_t        state;
  logic          upd;
  logic          full;
  logic [LW-1:0] raw;
  logic [LW-1:0] cand;
  logic [LW-1:0] pend;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  cmp_t          avg_c;
  cmp_t          bnd [MAX_L-1];

  acc_moving_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .sample       (i_sample),
    .sample_valid (i_sample_valid),
    .clear        (i_clear),
    .avg          (o_avg),
    .upd          (upd),
    .full         (full)
  );

  always_comb begin
    for (int k = 0; k < MAX_L - 1; k++)
      bnd[k] = '0;
    for (int k = 0; k < NUM_LEVELS - 1; k++)
      bnd[k] = cmp_t'($signed(i_bounds[k*DATA_W +: DATA_W]));
  end

  assign avg_c   = cmp_t'(o_avg);
  assign raw     = LW'(pick_level(avg_c, bnd, NUM_LEVELS));
  assign cnt_inc = cnt + 1'b1;

`ifdef ACC_LEVEL_HYST_EN
  logic [LW-1:0] lvl_dn;
  logic          up_ok;
  logic          dn_ok;

  // A rejected move looks like "stay at the committed level".
  assign lvl_dn = o_level - 1'b1;
  assign up_ok  = (raw > o_level) &&
                  (avg_c <= bnd[o_level] - cmp_t'(HYST));
  assign dn_ok  = (raw < o_level) &&
                  (avg_c > bnd[lvl_dn] + cmp_t'(HYST));
  assign cand   = (up_ok || dn_ok) ? raw : o_level;
`else
  assign cand = raw;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= FILL;
      o_level         <= '0;
      o_level_valid   <= 1'b0;
      o_level_changed <= 1'b0;
      pend            <= '0;
      cnt             <= '0;
    end else begin
      o_level_changed <= 1'b0;
      if (i_clear) begin
        state         <= FILL;
        o_level_valid <= 1'b0;
        pend          <= '0;
        cnt           <= '0;
      end else if (upd) begin
        unique case (state)
          FILL: begin
            if (full) begin
              o_level       <= raw;
              o_level_valid <= 1'b1;
              state         <= STABLE;
            end
          end
          STABLE: begin
            if (cand != o_level) begin
              if (HOLD_CNT == 1) begin
                o_level         <= cand;
                o_level_changed <= 1'b1;
              end else begin
                pend  <= cand;
                cnt   <= CW'(1);
                state <= PENDING;
              end
            end
          end
          PENDING: begin
            if (cand == o_level) begin
              state <= STABLE;
            end else if (cand == pend) begin
              cnt <= cnt_inc;
              if (cnt_inc == CW'(HOLD_CNT)) begin
                o_level         <= pend;
                o_level_changed <= 1'b1;
                state           <= STABLE;
              end
            end else begin
              pend <= cand;
              cnt  <= CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/acc_level_quantizer.md
ACC_LEVEL_QUANTIZER -- requirements
Module: acc_level_quantizer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DATA_W, 16: signed sample width.
- NUM_LEVELS, 8: number of output levels, minimum 2.
- AVG_LOG2, 2: log2 of the moving-average window depth.
- HOLD_CNT, 3: consecutive agreeing averages needed to commit a level change, minimum 1.
- HYST, 16: hysteresis margin in LSBs.

REQ-002 Ports SHALL be, as name, direction, width, meaning:
- i_clk, in, 1: sole clock.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_sample, in, DATA_W: signed acceleration sample.
- i_sample_valid, in, 1: single-cycle sample strobe.
- i_clear, in, 1: synchronous restart.
- i_bounds, in, (NUM_LEVELS-1)*DATA_W: signed lower bounds. Slice k holds the bound of level k. Intended descending.
- o_avg, out, DATA_W: signed windowed average.
- o_level, out, $clog2(NUM_LEVELS): committed level.
- o_level_valid, out, 1: o_level meaningful.
- o_level_changed, out, 1: one-cycle pulse on commit of a new level.

Function
REQ-003 Each accepted sample SHALL shift into a 2^AVG_LOG2 window and update a running sum of DATA_W+AVG_LOG2 bits as sum+new-oldest. The sum SHALL never overflow.
REQ-004 o_avg SHALL equal sum arithmetically shifted right by AVG_LOG2. It SHALL be registered one cycle after i_sample_valid.
REQ-005 Before the window is full, empty slots SHALL count as 0. A fill counter SHALL saturate at 2^AVG_LOG2.
REQ-006 The raw candidate level SHALL be the first k with o_avg > bound[k], searched by first-match priority from k=0. If no bound matches, the candidate SHALL be NUM_LEVELS-1. Non-monotonic bounds SHALL follow the same priority rule.
REQ-007 Every comparison SHALL be signed and carried at DATA_W+1 bits, so that bound±HYST cannot wrap.
REQ-008 The FSM states SHALL be FILL, STABLE and PENDING. Each decision SHALL occur one cycle after o_avg updates, i.e. 2 cycles after i_sample_valid.
REQ-009 FILL: on the decision for the sample that fills the window, commit the candidate directly, set o_level_valid=1, and go to STABLE. No o_level_changed pulse SHALL be issued.
REQ-010 STABLE: an accepted candidate different from o_level SHALL start PENDING with pend=candidate and cnt=1. If HOLD_CNT==1 it SHALL commit immediately instead.
REQ-011 PENDING transitions:
- candidate==o_level: return to STABLE.
- candidate==pend: cnt++. At cnt==HOLD_CNT, commit, pulse o_level_changed and go to STABLE.
- any other candidate: set pend=candidate and cnt=1.
REQ-012 Cycles without a decision SHALL leave the FSM state and cnt unchanged.
REQ-013 i_clear SHALL have priority over a same-cycle i_sample_valid, which is discarded. The next cycle SHALL show: window, sum and o_avg zero; state FILL; o_level_valid=0; o_level unchanged.

Reset
REQ-014 While i_rst_n=0, outputs SHALL be o_avg=0, o_level=0, o_level_valid=0 and o_level_changed=0. Internally the window, sum, fill counter, cnt and pend SHALL be 0 and the state SHALL be FILL.
REQ-015 Reset asserted mid-PENDING SHALL abandon the pending change with no o_level_changed pulse.

Configuration
REQ-016 With ACC_LEVEL_HYST_EN defined, STABLE/PENDING SHALL accept a candidate ≠ o_level only if o_avg <= bound[o_level]-HYST (moving to higher level) or o_avg > bound[o_level-1]+HYST (moving to lower level). A rejected candidate SHALL be treated as equal to o_level.
REQ-017 With ACC_LEVEL_HYST_EN undefined, the raw candidate SHALL be used unmodified, and the HYST parameter SHALL be ignored.

Structure
REQ-018 Package acc_level_pkg SHALL hold the FSM state enum, a function returning the candidate level, and the default parameter constants.
REQ-019 Sub-module acc_moving_avg SHALL contain the window, running sum, fill counter and o_avg register.

Verification
All scenarios use the defaults and bounds 1000,500,0,-500,-1000,-1500,-2000, with ACC_LEVEL_HYST_EN defined unless stated.
REQ-020 After reset, four samples of 600: o_avg=600 one cycle after the 4th sample; o_level=1 and o_level_valid=1 one cycle later; no o_level_changed pulse.
REQ-021 From level 1 at 600, continuous samples of 100: o_avg steps 475, 350, 225, 100. o_level SHALL commit 2 on the decision for 225 with a single o_level_changed pulse.
REQ-022 From level 1 at 600, continuous samples of 490: o_level stays 1 indefinitely. With the macro undefined, o_level becomes 2 after 3 decisions.
REQ-023 Four samples of -32768: o_avg=-32768 and o_level=7, with no sum overflow.
REQ-024 From level 1, averages giving candidates 2, 2, 3, 3, 3: commit 3 on the 5th decision, never 2.
REQ-025 i_clear together with i_sample_valid while PENDING: next cycle o_level_valid=0 and o_avg=0. The sample is discarded and no o_level_changed pulse occurs.
